// File: rtl/r4w_axil_cmd_master.sv
// r4w_axil_cmd_master: single-outstanding AXI4-Lite master driven by a valid/ready command port
// Ports: clk/rst (sync, active-high); cmd_* command in (cmd_ready high only in IDLE);
//        rsp_* response out (rdata, resp, timeout); busy = not IDLE; m_axi_* AXI4-Lite master.
// Option: define R4W_AXIL_TIMEOUT_EN to abort a stalled transaction after TIMEOUT_CYCLES clocks
//         with rsp_timeout=1, rsp_resp=SLVERR, rsp_rdata=0.
module r4w_axil_cmd_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("r4w_axil_cmd_master: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, rdata_q, rdata_n;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [1:0]              resp_q, resp_n;
    logic                    tmo_q, tmo_n;
    logic                    aw_q, w_q, ar_q, aw_done, w_done;
    logic                    aw_fin, w_fin, tmo, abort;

`ifdef R4W_AXIL_TIMEOUT_EN
    logic [15:0] cnt;
    assign tmo = state inside {WR, WR_B, RD_A, RD_R} && cnt == 16'(TIMEOUT_CYCLES);
    always_ff @(posedge clk)
        cnt <= (rst || state == IDLE) ? 16'd0 : cnt + 16'd1;
`else
    assign tmo = 1'b0;
`endif

    // A channel counts as finished if it completed earlier or handshakes this cycle.
    assign aw_fin = aw_done || (aw_q && m_axi_awready);
    assign w_fin  = w_done || (w_q && m_axi_wready);

    always_comb begin
        state_n = state;
        resp_n  = resp_q;
        rdata_n = rdata_q;
        tmo_n   = tmo_q;
        abort   = 1'b0;
        case (state)
            IDLE: if (cmd_valid) state_n = cmd_write ? WR : RD_A;
            WR:   if (aw_fin && w_fin) state_n = WR_B;
            WR_B: if (m_axi_bvalid) begin
                state_n = RSP;
                resp_n  = m_axi_bresp;
                rdata_n = '0;
                tmo_n   = 1'b0;
            end
            RD_A: if (m_axi_arready && ar_q) state_n = RD_R;
            RD_R: if (m_axi_rvalid) begin
                state_n = RSP;
                resp_n  = m_axi_rresp;
                rdata_n = m_axi_rdata;
                tmo_n   = 1'b0;
            end
            RSP:  if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A B/R handshake in the expiry cycle still wins; otherwise the watchdog aborts.
        if (tmo && state_n != RSP) begin
            abort   = 1'b1;
            state_n = RSP;
            resp_n  = 2'b10;
            rdata_n = '0;
            tmo_n   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_q    <= 1'b0;
            w_q     <= 1'b0;
            ar_q    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            resp_q  <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state   <= state_n;
            resp_q  <= resp_n;
            rdata_q <= rdata_n;
            tmo_q   <= tmo_n;
            // Valids launch on the first cycle of WR/RD_A and drop only on their own handshake.
            aw_q    <= state == WR && !abort && (aw_q ? !m_axi_awready : !aw_done);
            w_q     <= state == WR && !abort && (w_q ? !m_axi_wready : !w_done);
            ar_q    <= state == RD_A && !abort && !(ar_q && m_axi_arready);
            aw_done <= state == WR && aw_fin;
            w_done  <= state == WR && w_fin;
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
        end
    end

    assign cmd_ready     = state == IDLE;
    assign busy          = state != IDLE;
    assign rsp_valid     = state == RSP;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_timeout   = tmo_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = aw_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = w_q;
    assign m_axi_bready  = state == WR_B;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = ar_q;
    assign m_axi_rready  = state == RD_R;
endmodule

// File: tb/tb_r4w_axil_cmd_master.sv
// tb_r4w_axil_cmd_master: table-driven bench with a small register-file AXI-Lite slave model
module tb_r4w_axil_cmd_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    r4w_axil_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Slave model: ready after a programmable number of waiting cycles, B/R one cycle after completion.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic        ar_stall = 1'b0;
    int          aw_cnt, w_cnt, ar_cnt, aw_n = 0, w_n = 0;
    logic        got_aw, got_w;
    logic [7:0]  sa;
    logic [31:0] sd;
    logic [3:0]  ss;
    logic [31:0] mem [16];

    assign m_axi_awready = aw_cnt >= aw_dly;
    assign m_axi_wready  = w_cnt >= w_dly;
    assign m_axi_arready = !ar_stall && ar_cnt >= ar_dly;

    wire        aw_hs = m_axi_awvalid && m_axi_awready;
    wire        w_hs  = m_axi_wvalid && m_axi_wready;
    wire        ar_hs = m_axi_arvalid && m_axi_arready;
    wire [7:0]  ea = aw_hs ? m_axi_awaddr : sa;
    wire [31:0] ed = w_hs ? m_axi_wdata : sd;
    wire [3:0]  es = w_hs ? m_axi_wstrb : ss;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
            m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= 32'h0;
        end else begin
            aw_cnt <= aw_hs ? 0 : (m_axi_awvalid ? aw_cnt + 1 : aw_cnt);
            w_cnt  <= w_hs ? 0 : (m_axi_wvalid ? w_cnt + 1 : w_cnt);
            ar_cnt <= ar_hs ? 0 : (m_axi_arvalid ? ar_cnt + 1 : ar_cnt);
            if (aw_hs) begin got_aw <= 1'b1; sa <= m_axi_awaddr; end
            if (w_hs) begin got_w <= 1'b1; sd <= m_axi_wdata; ss <= m_axi_wstrb; end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                m_axi_bvalid <= 1'b1;
                m_axi_bresp  <= ea >= 8'h40 ? 2'b10 : 2'b00;
                if (ea < 8'h40 && ea != 8'h20)
                    for (int i = 0; i < 4; i++)
                        if (es[i]) mem[ea[5:2]][8*i +: 8] <= ed[8*i +: 8];
            end
            if (ar_hs) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rresp  <= m_axi_araddr >= 8'h40 ? 2'b10 : 2'b00;
                m_axi_rdata  <= m_axi_araddr >= 8'h40 ? 32'hBAD0BAD0 :
                                m_axi_araddr == 8'h20 ? 32'h5234494F : mem[m_axi_araddr[5:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && aw_hs) aw_n <= aw_n + 1;
        if (!rst && w_hs) w_n <= w_n + 1;
    end

    // Payload/valid stability monitor for every AXI request channel.
    logic       pa, pw, pr;
    logic [7:0] qa, qr;
    logic [31:0] qd;
    logic [3:0] qs;
    int         stab_err = 0;
    wire bad_aw = pa && (!m_axi_awvalid || m_axi_awaddr != qa);
    wire bad_w  = pw && (!m_axi_wvalid || m_axi_wdata != qd || m_axi_wstrb != qs);
    wire bad_ar = pr && (!m_axi_arvalid || m_axi_araddr != qr);

    always @(posedge clk) begin
        if (rst) begin
            pa <= 1'b0; pw <= 1'b0; pr <= 1'b0;
        end else begin
            stab_err <= stab_err + int'(bad_aw) + int'(bad_w) + int'(bad_ar);
            pa <= m_axi_awvalid && !m_axi_awready;
            pw <= m_axi_wvalid && !m_axi_wready;
            pr <= m_axi_arvalid && !m_axi_arready;
            qa <= m_axi_awaddr; qd <= m_axi_wdata; qs <= m_axi_wstrb; qr <= m_axi_araddr;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_d, w_d, ar_d, hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    task automatic run(input vec_t v);
        int          lat, aw0, w0;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        ok;
        aw_dly = v.aw_d; w_dly = v.w_d; ar_dly = v.ar_d;
        aw0 = aw_n; w0 = w_n;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("rdata", rsp_rdata, v.exp_rdata);
        chk("resp", 32'(rsp_resp), 32'(v.exp_resp));
        chk("timeout", 32'(rsp_timeout), 32'd0);
        if (v.wr) begin
            chk("aw_once", 32'(aw_n - aw0), 32'd1);
            chk("w_once", 32'(w_n - w0), 32'd1);
        end
        if (v.hold > 0) begin
            ok = 1'b1; rd = rsp_rdata; rs = rsp_resp;
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk); #1;
                if (!rsp_valid || cmd_ready || !busy || rsp_rdata != rd || rsp_resp != rs || rsp_timeout)
                    ok = 1'b0;
            end
            chk("hold_stable", 32'(ok), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk("idle_after", 32'({cmd_ready, rsp_valid, busy}), 32'(3'b100));
    endtask

    vec_t vt [10];

    initial begin
        #400000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat, seen;
        vt[0] = '{1'b1, 8'h04, 32'h01000000, 4'hF, 0, 0, 0, 0, 32'h0,        2'b00, 3};
        vt[1] = '{1'b0, 8'h04, 32'h0,        4'h0, 0, 0, 0, 0, 32'h01000000, 2'b00, 3};
        vt[2] = '{1'b0, 8'h20, 32'h0,        4'h0, 0, 0, 0, 0, 32'h5234494F, 2'b00, 3};
        vt[3] = '{1'b1, 8'h08, 32'hA5A5A5A5, 4'hF, 5, 0, 0, 0, 32'h0,        2'b00, 8};
        vt[4] = '{1'b1, 8'h08, 32'h12345678, 4'h5, 0, 5, 0, 10, 32'h0,       2'b00, 8};
        vt[5] = '{1'b0, 8'h08, 32'h0,        4'h0, 0, 0, 3, 10, 32'hA534A578, 2'b00, 6};
        vt[6] = '{1'b1, 8'h44, 32'h11111111, 4'hF, 2, 2, 0, 0, 32'h0,        2'b10, 5};
        vt[7] = '{1'b0, 8'h44, 32'h0,        4'h0, 0, 0, 0, 0, 32'hBAD0BAD0, 2'b10, 3};
        vt[8] = '{1'b1, 8'h0C, 32'hDEADBEEF, 4'hF, 3, 1, 0, 0, 32'h0,        2'b00, 6};
        vt[9] = '{1'b0, 8'h0C, 32'h0,        4'h0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 3};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                              m_axi_rready, rsp_valid, rsp_timeout, busy, cmd_ready}), 32'h001);
        chk("reset_rsp", 32'(rsp_rdata) | 32'(rsp_resp), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vt[k]) run(vt[k]);
        chk("payload_stable", 32'(stab_err), 32'd0);
        chk("prot_zero", 32'({m_axi_awprot, m_axi_arprot}), 32'd0);

`ifdef R4W_AXIL_TIMEOUT_EN
        ar_stall = 1'b1; ar_dly = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
        @(posedge clk); #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("wd_latency", 32'(lat), 32'd17);
        chk("wd_fields", {rsp_rdata[29:0], rsp_resp}, 32'(2'b10));
        chk("wd_rdata_hi", 32'(rsp_rdata[31:30]), 32'd0);
        chk("wd_timeout", 32'(rsp_timeout), 32'd1);
        chk("wd_valids", 32'({m_axi_arvalid, m_axi_rready}), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0; ar_stall = 1'b0;
        chk("wd_idle", 32'({cmd_ready, rsp_valid}), 32'(2'b10));
`endif

        aw_dly = 20; w_dly = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10;
        cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aw_pending", 32'(m_axi_awvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_write", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                 m_axi_rready, rsp_valid, busy, cmd_ready}), 32'h01);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid || !cmd_ready) seen++;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
